// File: rtl/pfpu_f2i.sv
// pfpu_f2i: 3-stage IEEE-754 single -> signed int32 converter (C cast semantics).
// Stage 1 unpacks, stage 2 aligns the significand, stage 3 applies sign/saturation.
module pfpu_f2i #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        alu_rst,
  input  logic [31:0] a,
  input  logic        valid_i,
  output logic [31:0] r,
  output logic        ovf,
  output logic        valid_o
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic               sign;
    logic [23:0]        sig;
    logic signed [8:0]  e;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        oor;
    logic [31:0] mag;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [31:0]     r_d;

  // Unpack: sign, hidden-bit significand, unbiased exponent.
  always_comb begin
    s1_d.sign = a[31];
    s1_d.sig  = {1'b1, a[22:0]};
    s1_d.e    = $signed({1'b0, a[30:23]}) - 9'sd127;
  end

  // Align: shift the significand into an integer magnitude, flag out-of-range.
  // Exponent 0 (zero/denormal) lands in the negative-e branch and yields 0.
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.oor  = 1'b0;
    s2_d.mag  = '0;
    if (s1_q.e[8]) begin
      s2_d.mag = '0;
    end else if (s1_q.e[7:0] <= 8'd23) begin
      s2_d.mag = {8'd0, s1_q.sig} >> (5'd23 - s1_q.e[4:0]);
    end else if (s1_q.e[7:0] <= 8'd30) begin
      s2_d.mag = {8'd0, s1_q.sig} << (s1_q.e[4:0] - 5'd23);
    end else if (s1_q.e[7:0] == 8'd31 && s1_q.sign && s1_q.sig == 24'h80_0000) begin
      // -2^31 is representable exactly; negation of 0x80000000 keeps it.
      s2_d.mag = 32'h8000_0000;
    end else begin
      s2_d.oor = 1'b1;
    end
  end

  // Sign/saturate: negate in-range magnitudes, substitute the out-of-range code.
  always_comb begin
    r_d = s2_q.sign ? (~s2_q.mag + 32'd1) : s2_q.mag;
    if (s2_q.oor) begin
      if (SATURATE) r_d = s2_q.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else          r_d = 32'h8000_0000;
    end
  end

  // Valid shift register; flush clears every stage and beats a same-cycle valid_i.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   vld_pipe <= '0;
    else if (alu_rst) vld_pipe <= '0;
    else              vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
  end

  // Stage 1/2 data only load under their valid; stale contents are harmless.
  always_ff @(posedge sys_clk) begin
    if (valid_i)     s1_q <= s1_d;
    if (vld_pipe[1]) s2_q <= s2_d;
  end

  // Output data register: cleared by reset only, never by flush.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r   <= '0;
      ovf <= 1'b0;
    end else if (vld_pipe[2]) begin
      r   <= r_d;
      ovf <= s2_q.oor;
    end
  end

  assign valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_pfpu_f2i.sv
// Scoreboard bench for pfpu_f2i: SATURATE=1 and SATURATE=0 instances share stimulus.
module tb_pfpu_f2i;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        alu_rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] r_s, r_w;
  logic        ovf_s, ovf_w, vo_s, vo_w;

  always #5 sys_clk = ~sys_clk;

  pfpu_f2i #(.SATURATE(1'b1)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .alu_rst(alu_rst),
    .a(a), .valid_i(valid_i), .r(r_s), .ovf(ovf_s), .valid_o(vo_s)
  );

  pfpu_f2i #(.SATURATE(1'b0)) dut_wrap (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .alu_rst(alu_rst),
    .a(a), .valid_i(valid_i), .r(r_w), .ovf(ovf_w), .valid_o(vo_w)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] r_s;
    logic        ovf_s;
    logic [31:0] r_w;
    logic        ovf_w;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cmp = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference: widen to double, compare range in real arithmetic, truncate with $rtoi.
  function automatic void model(input logic [31:0] x,
                                output logic [31:0] rs, output logic ovs,
                                output logic [31:0] rw, output logic ovw);
    logic [63:0] d;
    real         v;
    logic        oor;
    logic [31:0] ri;
    oor = 1'b0;
    ri  = '0;
    if (x[30:23] == 8'hFF) begin
      oor = 1'b1;
    end else if (x[30:23] != 8'h00) begin
      d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
      v = $bitstoreal(d);
      if (v >= 2147483648.0 || v < -2147483648.0) oor = 1'b1;
      else ri = $rtoi(v);
    end
    rs  = oor ? (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : ri;
    ovs = oor;
    rw  = oor ? 32'h8000_0000 : ri;
    ovw = oor;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Monitor: valid_o must match the scoreboard timing every cycle; data checked on pop.
  always @(negedge sys_clk) begin
    logic expv;
    exp_t e;
    expv = (q.size() > 0) && (q[0].cyc == cyc);
    check("valid_o_sat", 32'(vo_s), 32'(expv));
    check("valid_o_wrap", 32'(vo_w), 32'(expv));
    if (expv) begin
      e = q.pop_front();
      check($sformatf("r_sat[%h]", e.a), r_s, e.r_s);
      check($sformatf("ovf_sat[%h]", e.a), 32'(ovf_s), 32'(e.ovf_s));
      check($sformatf("r_wrap[%h]", e.a), r_w, e.r_w);
      check($sformatf("ovf_wrap[%h]", e.a), 32'(ovf_w), 32'(e.ovf_w));
    end
  end

  task automatic drive(input logic [31:0] x);
    exp_t e;
    e.a = x;
    model(x, e.r_s, e.ovf_s, e.r_w, e.ovf_w);
    e.cyc = cyc + 3;
    q.push_back(e);
    a = x;
    valid_i = 1'b1;
    n_vec++;
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    alu_rst = 1'b0;
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  logic [31:0] vecs [16] = '{
    32'hC030_0000, 32'h3F00_0000, 32'h4F00_0000, 32'hCF00_0000,
    32'h7FC0_0000, 32'h4EFF_FFFF, 32'hFF80_0000, 32'hBF00_0000,
    32'h0000_0001, 32'h8000_0000, 32'h4B7F_FFFF, 32'h4B80_0001,
    32'hCB80_0001, 32'hCEFF_FFFF, 32'h7F80_0000, 32'hCF00_0001
  };

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_r_sat", r_s, 32'h0);
    check("rst_ovf_sat", 32'(ovf_s), 32'h0);
    check("rst_r_wrap", r_w, 32'h0);
    check("rst_ovf_wrap", 32'(ovf_w), 32'h0);
    sys_rst_n = 1'b1;

    // First operand straight out of reset: 1.0
    drive(32'h3F80_0000);
    idle(5);

    // Directed boundaries back-to-back (throughput)
    foreach (vecs[i]) drive(vecs[i]);
    idle(5);

    // Random operands concentrated around the interesting exponents
    for (int i = 0; i < 24; i++)
      drive({1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)), 23'($urandom)});
    idle(5);

    // Flush with two operands in flight plus one discarded same-cycle operand
    drive(32'h4120_0000);
    drive(32'hC2C8_0000);
    a = 32'h4000_0000;
    valid_i = 1'b1;
    alu_rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    @(posedge sys_clk); #1;
    alu_rst = 1'b0;
    drive(32'h4040_0000);
    idle(6);

    // Asynchronous reset mid-stream
    drive(32'h4500_0000);
    drive(32'hC500_0000);
    drive(32'h4F00_0000);
    valid_i = 1'b0;
    #1;
    sys_rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_r_sat", r_s, 32'h0);
    check("midrst_ovf_sat", 32'(ovf_s), 32'h0);
    check("midrst_vo_sat", 32'(vo_s), 32'h0);
    check("midrst_r_wrap", r_w, 32'h0);
    check("midrst_vo_wrap", 32'(vo_w), 32'h0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(6);
    drive(32'hC0300000);
    idle(6);

    check("sb_drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pfpu_f2i.md
PFPU_F2I -- requirements
Module: pfpu_f2i

Interface
REQ-001 Parameter SATURATE, default 1: 1 clamps out-of-range results to the signed extremes; 0 returns 32'h80000000 for every out-of-range input.
REQ-002 sys_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 alu_rst  input  1  synchronous pipeline flush, active-high.
REQ-005 a  input  32  IEEE-754 single-precision operand.
REQ-006 valid_i  input  1  a is valid this cycle.
REQ-007 r  output  32  signed two's-complement integer result.
REQ-008 ovf  output  1  result was out of range, NaN or infinite; aligned with r.
REQ-009 valid_o  output  1  r and ovf are valid this cycle.

Function
REQ-010 The block SHALL convert a to a signed 32-bit integer, truncating toward zero (C cast semantics).
REQ-011 The block SHALL be a 3-stage pipeline: unpack, shift, sign/saturate; valid_o SHALL rise exactly 3 cycles after the valid_i sample.
REQ-012 The block SHALL accept a new operand every cycle; there is no backpressure and no ready signal.
REQ-013 Stage 1 SHALL register the sign, the 24-bit significand {1,a[22:0]} and the unbiased exponent e = a[30:23] - 127, held as a signed 9-bit value.
REQ-014 For a[30:23] = 0 (zero or denormal) the result SHALL be 0 and ovf SHALL be 0.
REQ-015 For e < 0 the result SHALL be 0 and ovf SHALL be 0; sign is ignored, so -0.5 yields 0.
REQ-016 For 0 <= e <= 23 stage 2 SHALL right-shift the significand by 23-e; for 24 <= e <= 30 it SHALL left-shift by e-23 into a 32-bit field.
REQ-017 Stage 3 SHALL two's-complement negate the magnitude when sign = 1.
REQ-018 For e >= 31, including a[30:23] = 255 (Inf/NaN), the input is out of range, with one exception: a = 32'hCF000000 (-2^31) is exact, SHALL yield 32'h80000000 and SHALL leave ovf at 0.
REQ-019 With SATURATE=1, out-of-range inputs SHALL yield 32'h7FFFFFFF for sign = 0 and 32'h80000000 for sign = 1. NaN follows its sign bit.
REQ-020 With SATURATE=0, out-of-range inputs SHALL yield 32'h80000000.
REQ-021 ovf SHALL be 1 exactly for out-of-range inputs under either SATURATE setting.
REQ-022 When a stage's valid bit is 0, its data registers MAY hold stale values.
REQ-023 r and ovf are don't-care while valid_o = 0 and SHALL NOT be relied on.
REQ-024 alu_rst = 1 SHALL clear all three stage valid bits on the next edge, so valid_o = 0 for at least 3 cycles after an alu_rst pulse.
REQ-025 If valid_i = 1 and alu_rst = 1 in the same cycle, alu_rst SHALL win and the operand SHALL be discarded.
REQ-026 Data registers SHALL NOT be cleared by alu_rst.
REQ-027 Each output SHALL depend only on its own operand; no state carries between operands.

Reset
REQ-028 While sys_rst_n = 0, all stage valid bits, valid_o, r and ovf SHALL be 0 asynchronously.
REQ-029 Operands in flight when reset asserts SHALL be lost and SHALL NOT appear after reset.
REQ-030 The first valid_i sampled after sys_rst_n deasserts SHALL produce valid_o exactly 3 cycles later.

Verification
REQ-031 Basic: a = 32'h3F800000 (1.0) with valid_i = 1 -> 3 cycles later valid_o = 1, r = 32'h00000001, ovf = 0.
REQ-032 Truncation: a = 32'hC0300000 (-2.75) -> r = 32'hFFFFFFFE (-2); a = 32'h3F000000 (0.5) -> r = 0, ovf = 0.
REQ-033 Boundaries at SATURATE=1:
- 32'h4F000000 (2^31) -> r = 32'h7FFFFFFF, ovf = 1.
- 32'hCF000000 -> r = 32'h80000000, ovf = 0.
- 32'h7FC00000 (NaN) -> r = 32'h7FFFFFFF, ovf = 1.
- 32'h4EFFFFFF -> r = 32'h7FFFFF80, ovf = 0.
REQ-034 SATURATE=0: 32'h4F000000 and 32'hFF800000 (-Inf) -> r = 32'h80000000, ovf = 1.
REQ-035 Throughput: 8 consecutive valid operands, one per cycle -> 8 consecutive valid_o cycles, in order, each matching a reference model.
REQ-036 Flush and reset:
- Assert alu_rst while 2 operands are in flight -> no valid_o for them; the next operand still takes 3 cycles.
- Pulse sys_rst_n low mid-stream -> outputs clear immediately and no stale result emerges.
